// File: rtl/apb_image_loader.sv
// APB master that packs a pixel stream into words, writes them to the CatRecognizer and samples CatRecOut.
// Latency: start->first SETUP 1 cycle; PIX_PER_WORD PACK + 2 bus cycles per word; done WAIT_CYCLES after GO ACCESS.
// Backpressure: pix_ready only in PACK while the word is not full. `APB_LOADER_SCORE_EN enables the pass/fail scoreboard.
module apb_image_loader #(
    parameter int DATA_W       = 8,
    parameter int PIX_PER_WORD = 3,
    parameter int AMBA_WORD    = DATA_W * PIX_PER_WORD,
    parameter int ADDR_W       = 13,
    parameter int NUM_PIXELS   = 12288,
    parameter int WAIT_CYCLES  = 4200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pix_valid,
    input  logic [DATA_W-1:0]    pix_data,
    output logic                 pix_ready,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDR_W-1:0]    PADDR,
    output logic [AMBA_WORD-1:0] PWDATA,
    input  logic                 cat_rec,
    input  logic                 exp_valid,
    input  logic                 exp_bit,
    output logic                 busy,
    output logic                 done,
    output logic                 result,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt
);
    localparam int NUM_WORDS = (NUM_PIXELS + PIX_PER_WORD - 1) / PIX_PER_WORD;
    localparam int PCW = $clog2(NUM_PIXELS + 1);
    localparam int WDW = $clog2(NUM_WORDS + 1);
    localparam int SLW = $clog2(PIX_PER_WORD + 1);
    localparam int WCW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLR, PACK, SETUP, ACCESS, GO, WAIT} state_t;
    typedef enum logic [1:0] {XF_CLR, XF_PIX, XF_GO} xfer_t;

    state_t               state;
    xfer_t                xfer;
    logic [PCW-1:0]       pix_cnt;
    logic [WDW-1:0]       word_cnt;
    logic [SLW-1:0]       slot;
    logic [AMBA_WORD-1:0] word;
    logic [AMBA_WORD-1:0] word_nxt;
    logic [WCW-1:0]       wait_cnt;
    logic                 abort_q;
    logic                 accept;
    logic                 word_end;
    logic                 sample;

    assign busy      = (state != IDLE);
    assign pix_ready = (state == PACK) && (slot < SLW'(PIX_PER_WORD));
    assign accept    = pix_valid && pix_ready;
    assign word_end  = (slot == SLW'(PIX_PER_WORD - 1)) || (pix_cnt == PCW'(NUM_PIXELS - 1));

    // First pixel lands in the MSB slot; unused low slots of a final partial word stay zero.
    always_comb begin
        int sh;
        sh       = (PIX_PER_WORD - 1 - int'(slot)) * DATA_W;
        word_nxt = word | (AMBA_WORD'(pix_data) << sh);
    end

    always_comb begin
        sample = 1'b0;
        if (state == WAIT && !abort && wait_cnt == WCW'(WAIT_CYCLES - 1))
            sample = 1'b1;
        if (state == ACCESS && xfer == XF_GO && !abort && !abort_q && WAIT_CYCLES == 1)
            sample = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            xfer     <= XF_CLR;
            pix_cnt  <= '0;
            word_cnt <= '0;
            slot     <= '0;
            word     <= '0;
            wait_cnt <= '0;
            abort_q  <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            done     <= 1'b0;
            result   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    pix_cnt  <= '0;
                    word_cnt <= '0;
                    slot     <= '0;
                    word     <= '0;
                    abort_q  <= 1'b0;
                    if (start) begin
                        state  <= CLR;
                        xfer   <= XF_CLR;
                        PSEL   <= 1'b1;
                        PWRITE <= 1'b1;
                        PADDR  <= '0;
                        PWDATA <= '0;
                    end
                end
                // An abort seen during SETUP is remembered so the ACCESS still completes.
                CLR, SETUP: begin
                    PENABLE <= 1'b1;
                    abort_q <= abort;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    abort_q <= 1'b0;
                    if (abort || abort_q) begin
                        state <= IDLE;
                    end else begin
                        case (xfer)
                            XF_GO: begin
                                if (sample) begin
                                    result <= cat_rec;
                                    done   <= 1'b1;
                                    state  <= IDLE;
                                end else begin
                                    wait_cnt <= WCW'(1);
                                    state    <= WAIT;
                                end
                            end
                            XF_PIX:  state <= (word_cnt == WDW'(NUM_WORDS)) ? GO : PACK;
                            default: state <= PACK;
                        endcase
                    end
                end
                PACK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept) begin
                        pix_cnt <= pix_cnt + PCW'(1);
                        if (word_end) begin
                            word     <= '0;
                            slot     <= '0;
                            word_cnt <= word_cnt + WDW'(1);
                            PADDR    <= ADDR_W'(word_cnt) + ADDR_W'(1);
                            PWDATA   <= word_nxt;
                            PSEL     <= 1'b1;
                            PWRITE   <= 1'b1;
                            xfer     <= XF_PIX;
                            state    <= SETUP;
                        end else begin
                            word <= word_nxt;
                            slot <= slot + SLW'(1);
                        end
                    end
                end
                GO: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        PSEL   <= 1'b1;
                        PWRITE <= 1'b1;
                        PADDR  <= '0;
                        PWDATA <= AMBA_WORD'(1);
                        xfer   <= XF_GO;
                        state  <= SETUP;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (sample) begin
                        result <= cat_rec;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APB_LOADER_SCORE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (sample && exp_valid) begin
            if (cat_rec == exp_bit) begin
                if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            end else begin
                if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_exp;
    assign unused_exp = exp_valid ^ exp_bit;
    assign pass_cnt   = '0;
    assign fail_cnt   = '0;
`endif

endmodule

// File: tb/tb_apb_image_loader.sv
// Bench for apb_image_loader: two instances (6- and 7-pixel images) checked every cycle against a write-list model.
`timescale 1ns/1ps
module tb_apb_image_loader;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_v = '0, abort_v = '0, pv = '0;
    logic [1:0][7:0] pd = '0;
    logic cat_rec = 1'b0, exp_valid = 1'b0, exp_bit = 1'b0;
    logic [1:0] pr, psel, pen, pwr, busy, done, res;
    logic [12:0] paddr [2];
    logic [23:0] pwdata [2];
    logic [15:0] pc [2];
    logic [15:0] fc [2];

    always #5 clk = ~clk;

    apb_image_loader #(.NUM_PIXELS(6), .WAIT_CYCLES(W)) u6 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .pix_valid(pv[0]), .pix_data(pd[0]), .pix_ready(pr[0]),
        .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .cat_rec(cat_rec), .exp_valid(exp_valid), .exp_bit(exp_bit),
        .busy(busy[0]), .done(done[0]), .result(res[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]));

    apb_image_loader #(.NUM_PIXELS(7), .WAIT_CYCLES(W)) u7 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .pix_valid(pv[1]), .pix_data(pd[1]), .pix_ready(pr[1]),
        .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .cat_rec(cat_rec), .exp_valid(exp_valid), .exp_bit(exp_bit),
        .busy(busy[1]), .done(done[1]), .result(res[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]));

    typedef struct { int id; logic [12:0] a; logic [23:0] d; } wr_t;
    wr_t exp_q[$];
    int  acc_cyc[$];
    int  checks = 0, failures = 0, cyc = 0;
    logic        in_setup [2];
    logic [12:0] s_a [2];
    logic [23:0] s_d [2];
    logic        exp_res [2];
    int due [2], go_cyc [2], done_cyc [2], done_cnt [2], epc [2], efc [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Word k of an n-pixel image whose pixel i carries value i+1, first pixel in the MSBs.
    function automatic logic [23:0] pack_word(input int n, input int k);
        logic [23:0] w;
        w = '0;
        for (int j = 0; j < 3; j++)
            if (k * 3 + j < n) w[(2 - j) * 8 +: 8] = 8'(k * 3 + j + 1);
        return w;
    endfunction

    task automatic expect_image(input int id, input int n, input bit go);
        exp_q.push_back('{id, 13'd0, 24'd0});
        for (int k = 0; k * 3 < n; k++) exp_q.push_back('{id, 13'(k + 1), pack_word(n, k)});
        if (go) exp_q.push_back('{id, 13'd0, 24'd1});
    endtask

    task automatic mon(input int id, input logic ps, input logic pe, input logic pw,
                       input logic [12:0] a, input logic [23:0] d, input logic bz, input logic rdy,
                       input logic dn, input logic r, input logic [15:0] p, input logic [15:0] f);
        wr_t e;
        if (!rst) begin
            chk("reset_outputs", {ps, pe, pw, bz, rdy, dn, r, |a, |d, |p, |f}, '0);
            in_setup[id] = 1'b0; due[id] = -1; exp_res[id] = 1'b0; epc[id] = 0; efc[id] = 0;
            return;
        end
        if (in_setup[id]) begin
            chk("access_phase", {ps, pe, pw}, 3'b111);
            chk("access_hold", {a, d}, {s_a[id], s_d[id]});
            in_setup[id] = 1'b0;
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_id", id, e.id);
                chk("write_addr", a, e.a);
                chk("write_data", d, e.d);
            end
            if (id == 0) acc_cyc.push_back(cyc);
            if (a == 13'd0 && d == 24'd1) begin due[id] = cyc + W; go_cyc[id] = cyc; end
        end else if (ps) begin
            chk("setup_phase", {pe, pw}, 2'b01);
            in_setup[id] = 1'b1; s_a[id] = a; s_d[id] = d;
        end else begin
            chk("bus_idle", {pe, pw}, 2'b00);
        end
        if (rdy) chk("ready_only_when_busy", {bz, ps}, 2'b10);
        if (dn) begin
            chk("done_time", cyc, due[id]);
            due[id] = -1; done_cyc[id] = cyc; done_cnt[id]++;
            exp_res[id] = cat_rec;
`ifdef APB_LOADER_SCORE_EN
            if (exp_valid) begin
                if (cat_rec == exp_bit) epc[id]++;
                else efc[id]++;
            end
`endif
            chk("done_returns_idle", bz, 0);
        end else if (due[id] == cyc) begin
            chk("done_missing", dn, 1);
            due[id] = -1;
        end
        chk("result_hold", r, exp_res[id]);
        chk("pass_cnt", p, epc[id]);
        chk("fail_cnt", f, efc[id]);
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, psel[0], pen[0], pwr[0], paddr[0], pwdata[0], busy[0], pr[0], done[0], res[0], pc[0], fc[0]);
        mon(1, psel[1], pen[1], pwr[1], paddr[1], pwdata[1], busy[1], pr[1], done[1], res[1], pc[1], fc[1]);
    end

    task automatic send_pix(input int id, input int first, input int n, input bit gaps);
        int g, t;
        for (int i = 0; i < n; i++) begin
            g = gaps ? (i % 6) : 0;
            if (g > 0) begin pv[id] = 1'b0; repeat (g) @(negedge clk); end
            pv[id] = 1'b1;
            pd[id] = 8'(first + i);
            t = 0;
            while (!pr[id] && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) begin
                chk("pixel_accepted", t, 0);
                pv[id] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        pv[id] = 1'b0;
    endtask

    task automatic start_pulse(input int id);
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
        chk("start_to_setup", {psel[id], pen[id]}, 2'b10);
    endtask

    task automatic run_image(input int id, input int n, input bit gaps);
        int prev, t;
        prev = done_cnt[id];
        expect_image(id, n, 1'b1);
        fork
            start_pulse(id);
            send_pix(id, 1, n, gaps);
        join
        t = 0;
        while (done_cnt[id] == prev && t < 300) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("done_seen", done_cnt[id], prev + 1);
        chk("writes_all_seen", exp_q.size(), 0);
    endtask

    initial begin
        int prevd;
        for (int i = 0; i < 2; i++) begin
            in_setup[i] = 1'b0; due[i] = -1; go_cyc[i] = 0; done_cyc[i] = 0;
            done_cnt[i] = 0; epc[i] = 0; efc[i] = 0; exp_res[i] = 1'b0;
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_idle", {psel[0], pen[0], busy[0], done[0], res[0], pr[0]}, '0);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-PACK: outputs clear without waiting for a clock edge.
        cat_rec = 1'b1;
        expect_image(0, 6, 1'b1);
        fork
            start_pulse(0);
            send_pix(0, 1, 4, 1'b0);
        join
        chk("mid_pack_busy", {busy[0], paddr[0]}, {1'b1, 13'd1});
        #2 rst = 1'b0;
        #1;
        chk("async_reset_clears", {psel[0], pen[0], pwr[0], busy[0], pr[0], paddr[0], pwdata[0]}, '0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Basic image, pixels back-to-back.
        chk("model_word1", pack_word(6, 0), 24'h010203);
        chk("model_word2", pack_word(6, 1), 24'h040506);
        acc_cyc.delete();
        cat_rec = 1'b1;
        run_image(0, 6, 1'b0);
        chk("basic_result", res[0], 1);
        chk("done_latency", done_cyc[0] - go_cyc[0], 10);
        chk("word1_cycles", acc_cyc[1] - acc_cyc[0], 5);
        chk("word2_cycles", acc_cyc[2] - acc_cyc[1], 5);

        // Backpressure: gaps of 0..5 cycles between pixels.
        cat_rec = 1'b0;
        run_image(0, 6, 1'b1);
        chk("bp_result", res[0], 0);

        // Partial final word on the 7-pixel instance.
        chk("model_partial", pack_word(7, 2), 24'h070000);
        cat_rec = 1'b1;
        run_image(1, 7, 1'b0);
        chk("partial_result", res[1], 1);

        // Abort during SETUP of word 2; a start while busy is ignored.
        prevd = done_cnt[0];
        expect_image(0, 6, 1'b0);
        fork
            start_pulse(0);
            begin
                send_pix(0, 1, 3, 1'b0);
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
                send_pix(0, 4, 3, 1'b0);
            end
        join
        chk("abort_in_setup", {psel[0], pen[0], paddr[0]}, {1'b1, 1'b0, 13'd2});
        abort_v[0] = 1'b1;
        @(negedge clk);
        chk("abort_access_completes", {psel[0], pen[0]}, 2'b11);
        @(negedge clk);
        abort_v[0] = 1'b0;
        pv[0] = 1'b1;
        chk("abort_idle", {busy[0], pr[0]}, 2'b00);
        @(negedge clk);
        pv[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt[0], prevd);
        chk("abort_writes", exp_q.size(), 0);
        chk("abort_keeps_result", res[0], 0);

        // Scoreboard.
        exp_valid = 1'b1; exp_bit = 1'b1; cat_rec = 1'b1;
        run_image(0, 6, 1'b0);
        exp_bit = 1'b0;
        run_image(0, 6, 1'b0);
        exp_valid = 1'b0;
`ifdef APB_LOADER_SCORE_EN
        chk("score_pass", pc[0], 1);
        chk("score_fail", fc[0], 1);
`else
        chk("score_pass_off", pc[0], 0);
        chk("score_fail_off", fc[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
